// File: rtl/fwd_pipe_pkg.sv
// fwd_pipe_pkg: shared pipeline forwarding encodings and shadow-record layout.
package fwd_pipe_pkg;
    localparam int REG_W = 5;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_IMM = 2'b11;
    typedef logic [REG_W-1:0] reg_t;
    typedef struct packed {
        logic valid;
        reg_t rs;
        reg_t rt;
        logic uses_rt;
        logic alusrc;
        reg_t rw;
        logic regwr;
        logic memtoreg;
    } pipe_rec_t;
    localparam pipe_rec_t REC_BUBBLE = '0;
    function automatic logic is_src(input pipe_rec_t r);
        return r.valid && r.regwr && (r.rw != '0);
    endfunction
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: per-operand forwarding select, MEM over WB, optional immediate override.
module fwd_sel
    import fwd_pipe_pkg::*;
(
    input  logic             ex_valid,
    input  logic             reads,
    input  logic             imm,
    input  logic [REG_W-1:0] src,
    input  logic             mem_ok,
    input  logic [REG_W-1:0] mem_rw,
    input  logic             wb_ok,
    input  logic [REG_W-1:0] wb_rw,
    output logic [1:0]       sel
);
    logic mem_hit, wb_hit;
    always_comb begin
        mem_hit = mem_ok && (mem_rw == src);
        wb_hit  = wb_ok && (wb_rw == src);
        sel = !ex_valid ? FWD_REG :
              imm       ? FWD_IMM :
              !reads    ? FWD_REG :
              mem_hit   ? FWD_MEM :
              wb_hit    ? FWD_WB  : FWD_REG;
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX/MEM/WB shadow records driving forwarding selects and load-use stall.
module fwd_hazard_unit
    import fwd_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_alusrc,
    input  logic [REG_W-1:0] id_rw,
    input  logic             id_regwr,
    input  logic             id_memtoreg,
    input  logic             flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             stall
);
    pipe_rec_t ex_q, mem_q, wb_q, ex_d, mem_d, wb_d, id_rec;
    logic [1:0] sel_a, sel_b;
    logic stall_raw, mem_ok, wb_ok, unused_wb;

    fwd_sel u_sel_a (
        .ex_valid(ex_q.valid), .reads(1'b1), .imm(1'b0), .src(ex_q.rs),
        .mem_ok(mem_ok), .mem_rw(mem_q.rw), .wb_ok(wb_ok), .wb_rw(wb_q.rw), .sel(sel_a)
    );
    fwd_sel u_sel_b (
        .ex_valid(ex_q.valid), .reads(ex_q.uses_rt), .imm(ex_q.alusrc), .src(ex_q.rt),
        .mem_ok(mem_ok), .mem_rw(mem_q.rw), .wb_ok(wb_ok), .wb_rw(wb_q.rw), .sel(sel_b)
    );

    always_comb begin
        id_rec = '{valid: id_valid, rs: id_rs, rt: id_rt, uses_rt: id_uses_rt,
                   alusrc: id_alusrc, rw: id_rw, regwr: id_regwr, memtoreg: id_memtoreg};
        // a load in MEM only has its address on MEMResult, so it never feeds 10
        mem_ok = is_src(mem_q) && !mem_q.memtoreg;
        wb_ok = is_src(wb_q);
        stall_raw = id_valid && is_src(ex_q) && ex_q.memtoreg &&
                    (ex_q.rw == id_rs || (id_uses_rt && ex_q.rw == id_rt));
        ex_d = (rst || !id_valid || stall_raw || flush) ? REC_BUBBLE : id_rec;
        mem_d = rst ? REC_BUBBLE : ex_q;
        wb_d = rst ? REC_BUBBLE : mem_q;
        stall = !rst && stall_raw;
        ForwardA = rst ? FWD_REG : sel_a;
        ForwardB = rst ? FWD_REG : sel_b;
        unused_wb = ^wb_q;
    end

    always_ff @(posedge clk) begin
        ex_q <= ex_d;
        mem_q <= mem_d;
        wb_q <= wb_d;
    end
endmodule
